ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs,
//  0xF4 enable) from the FPGA to the keyboard. It is the send-direction
//  counterpart of the scancode/break-code receive path on the same PS/2 port.
//  It drives open-collector enables only. Tri-state pads live at top level:
//  pad = oe ? 1'b0 : 1'bz.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles ps2c is held low before RTS (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  max clk cycles between device clock falling edges; <= 2^20-1
//  FILT_LEN        8       ps2c glitch-filter depth in clk cycles
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high
//  start      in   1  1-cycle request; sampled only in IDLE
//  din        in   8  byte to send; latched on the accepted start
//  ps2c_in    in   1  raw PS/2 clock pad input (asynchronous)
//  ps2d_in    in   1  raw PS/2 data pad input (asynchronous)
//  ps2c_oe    out  1  1 = pull PS/2 clock low
//  ps2d_oe    out  1  1 = pull PS/2 data low
//  busy       out  1  high from accepted start until done
//  done       out  1  1-cycle pulse at end of a transfer (success or error)
//  err        out  1  valid with done: 1 = NACK or timeout; holds until next start
// BEHAVIOUR
//  Reset: synchronous. All outputs are 0 (ps2c_oe=0, ps2d_oe=0, busy=0, done=0, err=0). State is IDLE.
//   Asserting reset mid-transfer releases both lines on the next clk edge. No done pulse is issued.
//  Input conditioning:
//   - ps2c_in and ps2d_in each pass through a 2-flop synchronizer.
//   - ps2c is then filtered. filt becomes 0 after FILT_LEN consecutive 0 samples and 1 after FILT_LEN consecutive 1 samples. Otherwise it holds.
//   - fall = filt was 1 last cycle and is 0 now.
//  All outputs are registered.
//  FSM (bit index n counts 0..10):
//   IDLE:
//    - On start: latch din, compute parity p = ~^din (odd parity), set busy=1 and err=0, clear the counter, go to INHIBIT.
//   INHIBIT:
//    - ps2c_oe=1.
//    - After INHIBIT_CYCLES clk cycles: ps2d_oe=1 (start bit 0), go to RTS.
//    - ps2c_oe=1 stays asserted on that cycle; it drops on entry to RTS.
//   RTS:
//    - ps2c_oe=0, ps2d_oe=1. Start the timeout counter and go to SHIFT with n=0.
//   SHIFT: on each fall, drive the next bit.
//    - fall #1..8 drive din[0]..din[7], LSB first.
//    - fall #9 drives p.
//    - fall #10 drives the stop bit: release ps2d_oe=0, then go to ACK.
//    - Drive rule: ps2d_oe = ~bit, so a 1 releases the line.
//   ACK:
//    - On the next fall, sample synced ps2d. 0 = ACK; 1 = NACK, which sets err=1.
//    - Then go to WAIT.
//   WAIT:
//    - Wait until filtered ps2c=1 and synced ps2d=1, then go to DONE.
//    - The timeout still applies.
//   DONE:
//    - done=1 for one cycle, busy=0, go to IDLE.
//  Timeout:
//   - In RTS/SHIFT/ACK/WAIT the 20-bit counter resets on every fall.
//   - If it reaches TIMEOUT_CYCLES: release both lines, set err=1, go to DONE.
//  Boundary conditions:
//   - start while busy is ignored; din is not re-latched.
//   - start and reset in the same cycle: reset wins.
//   - fall during INHIBIT is ignored, because the host holds the clock low.
//   - Back-to-back: start is accepted the cycle after done.
//  Latency: done follows the 11th device falling edge plus line release by at most 2+FILT_LEN+2 clk.
// TESTING
//  1 din=0xED: line bits 1,0,1,1,0,1,1,1, parity 1, stop released; device ACK=0 -> done=1, err=0.
//  2 din=0xF4: parity 0 on fall #9. din=0x00 and din=0xFF: parity 1. Check ps2d_oe per fall.
//  3 Check ps2c_oe=1 for exactly INHIBIT_CYCLES cycles, and ps2d_oe=1 before ps2c_oe falls to 0.
//  4 Device leaves data high at fall #11 (NACK) -> done pulse with err=1, both oe=0.
//  5 Device stops clocking after fall #4 -> after TIMEOUT_CYCLES: done=1, err=1, lines released.
//  6 Edge cases:
//    - 3-cycle glitch on ps2c: no bit advance.
//    - start during busy: ignored.
//    - reset at fall #5: next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts one command byte plus odd parity out on the device's clock edges.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILT_LEN       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_RTS     = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // INHIBIT ends one cycle early so the RTS cycle completes the clock-low window
    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 2);
    localparam logic [19:0] TO_LIMIT = 20'(TIMEOUT_CYCLES);

    logic                c_s1, c_s2, d_s1, d_s2;
    logic [FILT_LEN-1:0] c_hist;
    logic                filt, filt_q;
    logic                fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
            c_hist <= '1;
            filt   <= 1'b1;
            filt_q <= 1'b1;
        end else begin
            c_s1   <= ps2c_in;
            c_s2   <= c_s1;
            d_s1   <= ps2d_in;
            d_s2   <= d_s1;
            c_hist <= {c_hist[FILT_LEN-2:0], c_s2};
            if (&c_hist)
                filt <= 1'b1;
            else if (~|c_hist)
                filt <= 1'b0;
            filt_q <= filt;
        end
    end

    assign fall = filt_q & ~filt;

    logic [2:0]  state;
    logic [19:0] cnt;
    logic [3:0]  n;
    logic [8:0]  bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            n       <= '0;
            bits    <= '0;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bits    <= {~^din, din};
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        cnt     <= '0;
                        ps2c_oe <= 1'b1;
                        state   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        ps2d_oe <= 1'b1;
                        state   <= S_RTS;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                S_RTS: begin
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b1;
                    cnt     <= '0;
                    n       <= '0;
                    state   <= S_SHIFT;
                end
                S_SHIFT, S_ACK, S_WAIT: begin
                    if (cnt == TO_LIMIT) begin
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b0;
                        err     <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= fall ? 20'd0 : cnt + 20'd1;
                        if (state == S_SHIFT && fall) begin
                            n <= n + 4'd1;
                            if (n == 4'd9) begin
                                ps2d_oe <= 1'b0;
                                state   <= S_ACK;
                            end else begin
                                ps2d_oe <= ~bits[0];
                                bits    <= {1'b0, bits[8:1]};
                            end
                        end else if (state == S_ACK && fall) begin
                            err   <= d_s2;
                            n     <= n + 4'd1;
                            state <= S_WAIT;
                        end else if (state == S_WAIT && filt && d_s2) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host, checking each line bit and the completion status against a scoreboard.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TO  = 300;
    localparam int FL  = 4;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] din;
    logic       dev_c, dev_d;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe, busy, done, err;

    // open-collector bus: either side may pull low
    assign ps2c_in = ~ps2c_oe & dev_c;
    assign ps2d_in = ~ps2d_oe & dev_d;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILT_LEN(FL)) dut (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic       par;
        bit         nack;
        int         stop_after;
        bit         glitch;
        bit         busy_start;
        int         reset_at;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];
    logic exp_bits[$];
    logic exp_err[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (exp_err.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("done_err", err, exp_err.pop_front());
                chk("done_c_oe", ps2c_oe, 0);
                chk("done_d_oe", ps2d_oe, 0);
                chk("done_busy", busy, 0);
            end
            done_cnt++;
        end
    end

    task automatic xfer(input vec_t v);
        int   cnt;
        int   t;
        int   base;
        bit   seen_d;
        logic pre;
        base = done_cnt;
        for (int i = 0; i < 8; i++) exp_bits.push_back(v.din[i]);
        exp_bits.push_back(v.par);
        exp_bits.push_back(1'b1);
        exp_err.push_back(v.exp_err);
        @(negedge clk);
        din   = v.din;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din   = ~v.din;
        chk("busy_set", busy, 1);
        chk("err_clear", err, 0);
        cnt    = 0;
        seen_d = 1'b0;
        while (ps2c_oe && cnt < INH + 10) begin
            cnt++;
            if (ps2d_oe) seen_d = 1'b1;
            @(negedge clk);
        end
        chk("inhibit_len", cnt, INH);
        chk("data_before_clk_release", seen_d, 1);
        tick(3 * H);
        chk("start_bit", ps2d_in, 0);
        for (int k = 1; k <= 11; k++) begin
            if (v.stop_after != 0 && k > v.stop_after) break;
            if (k == 11 && !v.nack) dev_d = 1'b0;
            dev_c = 1'b0;
            tick(H);
            if (k == v.reset_at) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                chk("rst_c_oe", ps2c_oe, 0);
                chk("rst_d_oe", ps2d_oe, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                dev_c = 1'b1;
                exp_bits.delete();
                exp_err.delete();
                tick(50);
                chk("no_done_after_reset", done_cnt, base);
                return;
            end
            if (k <= 10) chk($sformatf("line_bit%0d", k), ps2d_in, exp_bits.pop_front());
            dev_c = 1'b1;
            tick(H);
            if (v.glitch && k == 3) begin
                pre   = ps2d_oe;
                dev_c = 1'b0;
                tick(3);
                dev_c = 1'b1;
                tick(H);
                chk("glitch_no_advance", ps2d_oe, pre);
            end
            if (v.busy_start && k == 2) begin
                din   = 8'h00;
                start = 1'b1;
                tick(1);
                start = 1'b0;
                chk("busy_hold", busy, 1);
            end
        end
        dev_d = 1'b1;
        t = 0;
        while (done_cnt == base && t < TO + 100) begin
            tick(1);
            t++;
        end
        chk("done_seen", done_cnt, base + 1);
        if (v.stop_after != 0)
            chk("timeout_window", (2 * H + t >= TO) && (2 * H + t <= TO + 20), 1);
        exp_bits.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //         din    par   nack stop glt  bsy  rst  err
        vecs[0] = '{8'hED, 1'b1, 0, 0, 0, 0, 0, 1'b0};
        vecs[1] = '{8'hF4, 1'b0, 0, 0, 0, 0, 0, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 0, 0, 0, 0, 0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 0, 0, 0, 0, 0, 1'b0};
        vecs[4] = '{8'hA5, 1'b1, 1, 0, 0, 0, 0, 1'b1};
        vecs[5] = '{8'h3C, 1'b1, 0, 4, 0, 0, 0, 1'b1};
        vecs[6] = '{8'h81, 1'b1, 0, 0, 1, 1, 0, 1'b0};
        vecs[7] = '{8'h55, 1'b1, 0, 0, 0, 0, 5, 1'b0};
        vecs[8] = '{8'h12, 1'b1, 0, 0, 0, 0, 0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        dev_c = 1'b1;
        dev_d = 1'b1;
        tick(5);
        chk("reset_c_oe", ps2c_oe, 0);
        chk("reset_d_oe", ps2d_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        reset = 1'b0;
        tick(5);

        reset = 1'b1;
        start = 1'b1;
        din   = 8'hAA;
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_wins_busy", busy, 0);
        chk("rst_wins_c_oe", ps2c_oe, 0);
        tick(3);
        chk("rst_wins_c_oe_later", ps2c_oe, 0);

        for (int i = 0; i < 9; i++) xfer(vecs[i]);

        tick(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
